test_supervisor: RTL and testbench

- Synthesizable run supervisor for f8 system tests, in simulation and on FPGA.
- Sequences the system reset after power-on and counts run cycles.
- Watches a vector of trap lines, with a grace window before stopping.
- Detects a pass code on a monitored status bus and enforces a timeout.
- Reports done, pass, fail cause and trap source as registered outputs, for a bench or an LED/UART reporter.

---
 rtl/test_supervisor_pkg.sv | 6 +
 rtl/test_supervisor_if.sv | 20 ++
 rtl/test_supervisor_pattern_stable_detect.sv | 22 ++
 rtl/test_supervisor.sv | 76 +++++++
 tb/tb_test_supervisor.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/test_supervisor_pkg.sv
// test_supervisor_pkg: shared state/fail-cause encodings for the run supervisor
package test_supervisor_pkg;
  localparam int FC_W = 2;
  typedef enum logic [1:0] {HOLD, RUN, GRACE, DONE} state_e;
  typedef enum logic [FC_W-1:0] {NONE, TRAP, TIMEOUT} fail_cause_e;
endpackage

// File: rtl/test_supervisor_if.sv
// test_supervisor_if: supervised-system observation bus and supervisor verdict outputs
interface test_supervisor_if import test_supervisor_pkg::*; #(
  parameter int NUM_TRAPS = 1,
  parameter int STATUS_W  = 8,
  parameter int CYCLE_W   = 16
);
  logic [NUM_TRAPS-1:0] trap;
  logic [STATUS_W-1:0]  status;
  logic                 system_reset;
  logic                 running;
  logic                 done;
  logic                 pass;
  logic [FC_W-1:0]      fail_cause;
  logic [NUM_TRAPS-1:0] trap_source;
  logic [CYCLE_W-1:0]   cycle_count;
  modport master (input trap, status,
                  output system_reset, running, done, pass, fail_cause, trap_source, cycle_count);
  modport slave  (output trap, status,
                  input system_reset, running, done, pass, fail_cause, trap_source, cycle_count);
endinterface

// File: rtl/test_supervisor_pattern_stable_detect.sv
// pattern_stable_detect: flags when value has equalled CODE for COUNT consecutive enabled cycles, current cycle included
module pattern_stable_detect #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] CODE  = '0,
  parameter int               COUNT = 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] value,
  output logic             match
);
  localparam int CW = COUNT > 1 ? $clog2(COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(COUNT - 1);
  logic [CW-1:0] cnt;
  logic          hit;
  assign hit   = value == CODE;
  assign match = enable && hit && cnt == LAST;
  always_ff @(posedge clk)
    if (clear || (enable && !hit)) cnt <= '0;
    else if (enable && cnt != LAST) cnt <= cnt + 1'b1;
endmodule

// File: rtl/test_supervisor.sv
// test_supervisor: sequences system reset, watches traps/pass code/timeout and reports a registered verdict
module test_supervisor import test_supervisor_pkg::*; #(
  parameter int                  NUM_TRAPS         = 1,
  parameter int                  STATUS_W          = 8,
  parameter logic [STATUS_W-1:0] PASS_CODE         = 8'hA5,
  parameter int                  PASS_STABLE       = 4,
  parameter int                  RESET_CYCLES      = 5,
  parameter int                  TRAP_GRACE_CYCLES = 5,
  parameter int                  TIMEOUT_CYCLES    = 2045,
  parameter int                  CYCLE_W           = 16
) (
  input logic                clk,
  input logic                power_on_reset,
  test_supervisor_if.master  bus
);
  localparam int HW = RESET_CYCLES > 0 ? $clog2(RESET_CYCLES + 1) : 1;
  localparam int GW = TRAP_GRACE_CYCLES > 1 ? $clog2(TRAP_GRACE_CYCLES) : 1;
  localparam logic [HW-1:0]      HOLD_LAST  = HW'(RESET_CYCLES);
  localparam logic [GW-1:0]      GRACE_LAST = GW'(TRAP_GRACE_CYCLES > 0 ? TRAP_GRACE_CYCLES - 1 : 0);
  localparam logic [CYCLE_W-1:0] TO_LAST    = CYCLE_W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  if (longint'(TIMEOUT_CYCLES) > (longint'(1) << CYCLE_W) || PASS_STABLE < 1) begin : g_bad_params
    $fatal(1, "test_supervisor: TIMEOUT_CYCLES exceeds 2^CYCLE_W or PASS_STABLE < 1");
  end
  state_e        state, nxt;
  logic [HW-1:0] hold_cnt;
  logic [GW-1:0] grace_cnt;
  logic          trapped, pass_hit, timed_out, live;
  assign trapped   = |bus.trap;
  assign timed_out = TIMEOUT_CYCLES != 0 && bus.cycle_count == TO_LAST && bus.cycle_count != '1;
  assign live      = nxt == RUN || nxt == GRACE;
  pattern_stable_detect #(.WIDTH(STATUS_W), .CODE(PASS_CODE), .COUNT(PASS_STABLE)) u_stable (
    .clk    (clk),
    .clear  (power_on_reset || state != RUN),
    .enable (state == RUN),
    .value  (bus.status),
    .match  (pass_hit)
  );
  always_ff @(posedge clk) state <= power_on_reset ? HOLD : nxt;
  always_comb begin
    nxt = state;
    if (state == HOLD) nxt = hold_cnt == HOLD_LAST ? RUN : HOLD;
    else if (state == RUN) nxt = trapped ? (TRAP_GRACE_CYCLES == 0 ? DONE : GRACE) : (pass_hit || timed_out) ? DONE : RUN;
    else if (state == GRACE && grace_cnt == GRACE_LAST) nxt = DONE;
  end
  // DONE freezes every status register until the next power-on reset
  always_ff @(posedge clk)
    if (power_on_reset) begin
      hold_cnt         <= '0;
      grace_cnt        <= '0;
      bus.system_reset <= 1'b1;
      bus.running      <= 1'b0;
      bus.done         <= 1'b0;
      bus.pass         <= 1'b0;
      bus.fail_cause   <= NONE;
      bus.trap_source  <= '0;
      bus.cycle_count  <= '0;
    end else if (state != DONE) begin
      bus.system_reset <= !live;
      bus.running      <= live;
      bus.done         <= nxt == DONE;
      if (state == HOLD) hold_cnt <= hold_cnt + 1'b1;
      else begin
        if (bus.cycle_count != '1) bus.cycle_count <= bus.cycle_count + 1'b1;
        if (state == GRACE) begin
          grace_cnt       <= grace_cnt + 1'b1;
          bus.trap_source <= bus.trap_source | bus.trap;
        end else if (trapped) begin
          bus.trap_source <= bus.trap;
          bus.fail_cause  <= TRAP;
        end else if (nxt == DONE) begin
          bus.pass       <= pass_hit;
          bus.fail_cause <= pass_hit ? NONE : TIMEOUT;
        end
      end
    end
endmodule

// File: tb/tb_test_supervisor.sv
// tb_test_supervisor: directed checks of reset sequencing, pass, trap, timeout and zero-cycle parameters
module tb_test_supervisor;
  logic clk = 1'b0;
  logic por_a, por_z;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  test_supervisor_if #(.NUM_TRAPS(3)) bus_a ();
  test_supervisor_if #(.NUM_TRAPS(3)) bus_z ();

  test_supervisor #(.NUM_TRAPS(3)) dut_a (
    .clk            (clk),
    .power_on_reset (por_a),
    .bus            (bus_a)
  );

  test_supervisor #(.NUM_TRAPS(3), .RESET_CYCLES(0), .TRAP_GRACE_CYCLES(0)) dut_z (
    .clk            (clk),
    .power_on_reset (por_z),
    .bus            (bus_z)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_to(input int k);
    while (cyc < k) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic restart_a();
    por_a = 1'b1;
    repeat (2) @(negedge clk);
    por_a = 1'b0;
    repeat (6) @(negedge clk);
    cyc = 0;
    chk("restart_running", bus_a.running, 1);
    chk("restart_cc", bus_a.cycle_count, 0);
  endtask

  initial begin
    bus_a.trap = '0; bus_a.status = '0;
    bus_z.trap = '0; bus_z.status = '0;
    por_a = 1'b1; por_z = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_sysreset", bus_a.system_reset, 1);
    chk("rst_running", bus_a.running, 0);
    chk("rst_done", bus_a.done, 0);
    chk("rst_pass", bus_a.pass, 0);
    chk("rst_fc", bus_a.fail_cause, 0);
    chk("rst_ts", bus_a.trap_source, 0);
    chk("rst_cc", bus_a.cycle_count, 0);
    por_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("hold_sysreset", bus_a.system_reset, 1);
    end
    @(negedge clk);
    chk("run_sysreset", bus_a.system_reset, 0);
    chk("run_running", bus_a.running, 1);
    chk("run_cc0", bus_a.cycle_count, 0);
    cyc = 0;
    run_to(1);
    chk("run_cc1", bus_a.cycle_count, 1);
    run_to(2);
    chk("run_cc2", bus_a.cycle_count, 2);

    // pass detection with an interrupted run first
    run_to(47); bus_a.status = 8'hA5;
    run_to(50); bus_a.status = 8'hA4;
    run_to(51); bus_a.status = 8'hA5;
    run_to(54); bus_a.status = 8'h00;
    chk("glitch_no_pass", bus_a.done, 0);
    chk("glitch_cc", bus_a.cycle_count, 54);
    run_to(100); bus_a.status = 8'hA5;
    run_to(103);
    chk("pass_not_early", bus_a.done, 0);
    run_to(104);
    chk("pass_done", bus_a.done, 1);
    chk("pass_pass", bus_a.pass, 1);
    chk("pass_fc", bus_a.fail_cause, 0);
    chk("pass_running", bus_a.running, 0);
    chk("pass_sysreset", bus_a.system_reset, 1);
    chk("pass_cc", bus_a.cycle_count, 104);
    bus_a.status = 8'h00;
    bus_a.trap = 3'b111;
    repeat (3) @(negedge clk);
    bus_a.trap = '0;
    chk("frozen_cc", bus_a.cycle_count, 104);
    chk("frozen_done", bus_a.done, 1);
    chk("frozen_ts", bus_a.trap_source, 0);

    // trap with grace window, second trap merged into trap_source
    restart_a();
    run_to(40); bus_a.trap = 3'b010;
    run_to(41); bus_a.trap = 3'b000;
    chk("trap_fc", bus_a.fail_cause, 1);
    chk("trap_ts1", bus_a.trap_source, 3'b010);
    chk("trap_done0", bus_a.done, 0);
    chk("trap_running", bus_a.running, 1);
    run_to(42); bus_a.trap = 3'b100;
    run_to(43); bus_a.trap = 3'b000;
    run_to(45);
    chk("grace_not_done", bus_a.done, 0);
    run_to(46);
    chk("grace_done", bus_a.done, 1);
    chk("grace_pass", bus_a.pass, 0);
    chk("grace_ts", bus_a.trap_source, 3'b110);
    chk("grace_fc", bus_a.fail_cause, 1);
    chk("grace_cc", bus_a.cycle_count, 46);
    chk("grace_running", bus_a.running, 0);

    // trap and completing pass match in the same cycle
    restart_a();
    run_to(20); bus_a.status = 8'hA5;
    run_to(23); bus_a.trap = 3'b001;
    run_to(24); bus_a.trap = 3'b000; bus_a.status = 8'h00;
    chk("tie_fc", bus_a.fail_cause, 1);
    chk("tie_done0", bus_a.done, 0);
    chk("tie_pass", bus_a.pass, 0);
    run_to(29);
    chk("tie_done", bus_a.done, 1);
    chk("tie_pass_final", bus_a.pass, 0);

    // reset during GRACE
    restart_a();
    run_to(10); bus_a.trap = 3'b001;
    run_to(12); bus_a.trap = 3'b000;
    chk("mid_in_grace", bus_a.running, 1);
    chk("mid_fc_trap", bus_a.fail_cause, 1);
    por_a = 1'b1;
    @(negedge clk);
    chk("mid_done", bus_a.done, 0);
    chk("mid_fc", bus_a.fail_cause, 0);
    chk("mid_ts", bus_a.trap_source, 0);
    chk("mid_cc", bus_a.cycle_count, 0);
    chk("mid_sysreset", bus_a.system_reset, 1);
    chk("mid_running", bus_a.running, 0);
    por_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk("rehold_sysreset", bus_a.system_reset, 1);
    end
    @(negedge clk);
    chk("rerun_running", bus_a.running, 1);
    chk("rerun_cc", bus_a.cycle_count, 0);
    cyc = 0;

    // timeout
    run_to(2044);
    chk("to_cc", bus_a.cycle_count, 2044);
    chk("to_not_done", bus_a.done, 0);
    run_to(2045);
    chk("to_done", bus_a.done, 1);
    chk("to_fc", bus_a.fail_cause, 2);
    chk("to_pass", bus_a.pass, 0);
    chk("to_running", bus_a.running, 0);
    chk("to_cc_final", bus_a.cycle_count, 2045);
    @(negedge clk);
    chk("to_running_after", bus_a.running, 0);

    // zero reset-hold and zero grace
    chk("z_rst_sysreset", bus_z.system_reset, 1);
    chk("z_rst_cc", bus_z.cycle_count, 0);
    por_z = 1'b0;
    @(negedge clk);
    chk("z_running", bus_z.running, 1);
    chk("z_sysreset", bus_z.system_reset, 0);
    chk("z_cc0", bus_z.cycle_count, 0);
    repeat (3) @(negedge clk);
    chk("z_cc3", bus_z.cycle_count, 3);
    bus_z.trap = 3'b100;
    @(negedge clk);
    bus_z.trap = 3'b000;
    chk("z_done", bus_z.done, 1);
    chk("z_fc", bus_z.fail_cause, 1);
    chk("z_ts", bus_z.trap_source, 3'b100);
    chk("z_pass", bus_z.pass, 0);
    chk("z_cc", bus_z.cycle_count, 4);
    chk("z_running_off", bus_z.running, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
